// File: rtl/mips32_mem_arbiter_pkg.sv
// Shared types and defaults for the mips32 shared-memory arbiter.
// FSM state encoding, transaction owner encoding and default bus widths.
package mips32_mem_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the arbiter and the memory array.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory.
interface mips32_mem_arbiter_if
  import mips32_mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_mem_arbiter_starve.sv
// Fairness logic: counts data grants taken while a fetch waits and forces
// the fetch through once the count reaches STARVE_MAX.
module mem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_live,
  input  logic d_live,
  input  logic grant,
  output logic pick_if
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  assign pick_if = if_live && (!d_live || (cnt_q == CNT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req) begin
      cnt_d = '0;
    end else if (grant) begin
      if (pick_if) begin
        cnt_d = '0;
      end else if (if_live && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Serialises fetch and data accesses onto one single-port synchronous memory:
// IDLE arbitrates, CMD strobes the memory, RSP captures read data; ack follows in IDLE.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips32_mem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          store_q, store_d;
  logic          drop_q, drop_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic if_live, d_live, grant, pick_if, drop_now;

  // A port being acked this cycle must not re-win with the request it just completed.
  assign if_live  = bus.if_req && !if_ack_q && !bus.if_flush;
  assign d_live   = bus.d_req && !d_ack_q;
  assign grant    = (state_q == IDLE) && (if_live || d_live);
  assign drop_now = drop_q || (bus.if_flush && (owner_q == OWN_IF) && (state_q != IDLE));

  mem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (bus.if_req),
    .if_live (if_live),
    .d_live  (d_live),
    .grant   (grant),
    .pick_if (pick_if)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    drop_d      = drop_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = CMD;
          mem_en_d = 1'b1;
          drop_d   = 1'b0;
          if (pick_if) begin
            owner_d    = OWN_IF;
            store_d    = 1'b0;
            mem_addr_d = bus.if_addr;
          end else begin
            owner_d     = OWN_D;
            store_d     = bus.d_we;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end
        end
      end
      CMD: begin
        state_d = RSP;
        drop_d  = drop_now;
      end
      RSP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
        if (owner_q == OWN_IF) begin
          if (!drop_now) begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          d_ack_d = 1'b1;
          if (!store_q) d_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      store_q     <= 1'b0;
      drop_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      drop_q      <= drop_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed scenarios then random traffic, checked by a
// transaction-level reference model feeding expectation queues drained by a monitor.
module tb_mips32_mem_arbiter;
  import mips32_mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int SMAX  = 4;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mips32_mem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single-port synchronous memory: read data appears the cycle after mem_en.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] mem_rd = '0;
  assign bus.mem_rdata = mem_rd;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else            mem_rd <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int            cyc;
    logic          is_if;
    logic [DW-1:0] data;
  } ack_exp_t;

  mem_exp_t mq[$];
  ack_exp_t aq[$];

  // Reference model: each grant books the memory for three cycles and schedules its ack.
  int            cyc = 0;
  int            next_free = 0;
  int            g_cyc = -100;
  logic          g_if = 1'b0;
  logic          g_we = 1'b0;
  logic          g_drop = 1'b0;
  logic [DW-1:0] g_data = '0;
  int            if_ack_at = -1;
  int            d_ack_at = -1;
  int            starve = 0;
  logic [DW-1:0] ref_if_rd = '0;
  logic [DW-1:0] ref_d_rd = '0;

  always @(posedge clk) begin
    int   t;
    logic fl, dl, take_if;
    t = cyc;
    if (!rst_n) begin
      next_free = 0; g_cyc = -100; g_if = 1'b0; g_we = 1'b0; g_drop = 1'b0;
      if_ack_at = -1; d_ack_at = -1; starve = 0;
      ref_if_rd = '0; ref_d_rd = '0;
      mq.delete(); aq.delete();
    end else begin
      if (g_if && (t == g_cyc + 1 || t == g_cyc + 2) && bus.if_flush) g_drop = 1'b1;
      if (t == g_cyc + 2) begin
        if (g_if) begin
          if (!g_drop) begin
            ref_if_rd = g_data;
            aq.push_back('{t + 3 - 2, 1'b1, g_data});
            if_ack_at = t + 1;
          end
        end else begin
          if (!g_we) ref_d_rd = g_data;
          aq.push_back('{t + 1, 1'b0, ref_d_rd});
          d_ack_at = t + 1;
        end
      end
      fl = bus.if_req && !bus.if_flush && (t != if_ack_at);
      dl = bus.d_req && (t != d_ack_at);
      take_if = fl && (!dl || starve == SMAX);
      if (t >= next_free && (fl || dl)) begin
        g_cyc = t; next_free = t + 3; g_drop = 1'b0; g_if = take_if;
        if (take_if) begin
          g_we   = 1'b0;
          g_data = ref_mem[bus.if_addr];
          mq.push_back('{t + 1, 1'b0, bus.if_addr, '0});
        end else begin
          g_we = bus.d_we;
          if (bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
          else          g_data = ref_mem[bus.d_addr];
          mq.push_back('{t + 1, bus.d_we, bus.d_addr, bus.d_wdata});
        end
        if (!bus.if_req)   starve = 0;
        else if (take_if)  starve = 0;
        else if (fl && starve < SMAX) starve++;
      end else if (!bus.if_req) begin
        starve = 0;
      end
    end
    cyc = t + 1;
  end

  // Monitor: compares every memory strobe and ack against the head of its queue.
  always begin
    mem_exp_t me;
    ack_exp_t ae;
    @(posedge clk);
    #1;
    if (rst_n) begin
      while (mq.size() > 0 && mq[0].cyc < cyc) begin
        chk("mem_missing_cycle", DW'(cyc), DW'(mq[0].cyc));
        void'(mq.pop_front());
      end
      while (aq.size() > 0 && aq[0].cyc < cyc) begin
        chk("ack_missing_cycle", DW'(cyc), DW'(aq[0].cyc));
        void'(aq.pop_front());
      end
      if (bus.mem_en) begin
        if (mq.size() == 0) begin
          chk("mem_unexpected_en", DW'(bus.mem_en), '0);
        end else begin
          me = mq.pop_front();
          chk("mem_cycle", DW'(cyc), DW'(me.cyc));
          chk("mem_we", DW'(bus.mem_we), DW'(me.we));
          chk("mem_addr", DW'(bus.mem_addr), DW'(me.addr));
          if (me.we) chk("mem_wdata", bus.mem_wdata, me.wdata);
        end
      end else begin
        chk("mem_we_without_en", DW'(bus.mem_we), '0);
      end
      if (bus.if_ack || bus.d_ack) begin
        chk("ack_both", DW'(bus.if_ack && bus.d_ack), '0);
        if (aq.size() == 0) begin
          chk("ack_unexpected", DW'({bus.if_ack, bus.d_ack}), '0);
        end else begin
          ae = aq.pop_front();
          chk("ack_cycle", DW'(cyc), DW'(ae.cyc));
          chk("ack_port_is_if", DW'(bus.if_ack), DW'(ae.is_if));
          chk("ack_data", ae.is_if ? bus.if_rdata : bus.d_rdata, ae.data);
        end
      end
      chk("if_rdata_hold", bus.if_rdata, ref_if_rd);
      chk("d_rdata_hold", bus.d_rdata, ref_d_rd);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.if_flush = 1'b0; bus.d_we = 1'b0;
    step(n);
  endtask

  task automatic wait_ack(input bit is_if, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_if ? bus.if_ack : bus.d_ack) && n < lim);
    if (!(is_if ? bus.if_ack : bus.d_ack)) chk(is_if ? "if_ack_timeout" : "d_ack_timeout", DW'(n), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, DW'(bus.mem_en), '0);
    chk({tag, "_mem_we"}, DW'(bus.mem_we), '0);
    chk({tag, "_mem_addr"}, DW'(bus.mem_addr), '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    chk({tag, "_if_ack"}, DW'(bus.if_ack), '0);
    chk({tag, "_d_ack"}, DW'(bus.d_ack), '0);
    chk({tag, "_if_rdata"}, bus.if_rdata, '0);
    chk({tag, "_d_rdata"}, bus.d_rdata, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    #2 rst_n = 1'b0;
    step(2);
    check_reset_outputs("por");
    rst_n = 1'b1;
    step(2);

    // Fetch only
    bus.if_req = 1'b1; bus.if_addr = AW'(5);
    wait_ack(1'b1, 10);
    chk("fetch_deadbeef", bus.if_rdata, 32'hDEADBEEF);
    idle(4);

    // Conflict: data first, fetch at the data ack cycle
    bus.if_req = 1'b1; bus.if_addr = AW'(1);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(7);
    wait_ack(1'b0, 10);
    bus.d_req = 1'b0;
    wait_ack(1'b1, 10);
    idle(4);

    // Both requesters held continuously
    bus.if_req = 1'b1; bus.if_addr = AW'($urandom_range(0, 15));
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'($urandom_range(0, 15));
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.d_ack) begin
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = AW'($urandom_range(0, 15));
        bus.d_wdata = $urandom;
      end
      if (bus.if_ack) bus.if_addr = AW'($urandom_range(0, 15));
    end
    idle(6);

    // Store then load of the same word
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = AW'(3); bus.d_wdata = 32'h12345678;
    wait_ack(1'b0, 10);
    bus.d_we = 1'b0;
    wait_ack(1'b0, 10);
    chk("store_load_3", bus.d_rdata, 32'h12345678);
    idle(4);

    // Flush during fetch CMD with a data request pending
    bus.if_req = 1'b1; bus.if_addr = AW'(9);
    step(1);
    bus.if_flush = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(11);
    step(1);
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    wait_ack(1'b0, 10);
    bus.d_req = 1'b0;
    idle(4);

    // Reset while a fetch sits in RSP
    bus.if_req = 1'b1; bus.if_addr = AW'(2);
    step(2);
    bus.if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_rsp");
    step(2);
    rst_n = 1'b1;
    idle(8);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1);
      bus.if_flush = ($urandom_range(0, 11) == 0);
      if (bus.if_flush) begin
        bus.if_addr = AW'($urandom_range(0, 15));
        bus.if_req = 1'($urandom_range(0, 1));
      end else if (!bus.if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.if_req = 1'b1;
          bus.if_addr = AW'($urandom_range(0, 15));
        end
      end else if (bus.if_ack) begin
        bus.if_req = 1'($urandom_range(0, 1));
        bus.if_addr = AW'($urandom_range(0, 15));
      end
      if (!bus.d_req || bus.d_ack) begin
        if (bus.d_ack && $urandom_range(0, 1) == 0) begin
          bus.d_req = 1'b0;
        end else if (bus.d_ack || $urandom_range(0, 2) == 0) begin
          bus.d_req = 1'b1;
          bus.d_we = 1'($urandom_range(0, 1));
          bus.d_addr = AW'($urandom_range(0, 15));
          bus.d_wdata = $urandom;
        end
      end
    end
    idle(10);

    chk("mem_queue_drained", DW'(mq.size()), '0);
    chk("ack_queue_drained", DW'(aq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
